ram_stream_reader: RTL
======================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of RAM data and stream.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, RAM address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 11, command length width in words.
REQ-004 SHALL have parameter RD_LATENCY, default 1, RAM read latency in cycles; legal values 1 and 2.
REQ-005 SHALL have port i_clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_cmd_valid  in  1  read command valid.
REQ-008 SHALL have port o_cmd_ready  out  1  command accepted when valid&ready.
REQ-009 SHALL have port i_cmd_addr  in  ADDR_WIDTH  first word address.
REQ-010 SHALL have port i_cmd_len  in  LEN_WIDTH  word count; 0 legal.
REQ-011 SHALL have port o_ram_en  out  1  RAM read-port enable.
REQ-012 SHALL have port o_ram_addr  out  ADDR_WIDTH  RAM read address.
REQ-013 SHALL have port i_ram_data  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after o_ram_en.
REQ-014 SHALL have ports o_tvalid/o_tdata/o_tlast  out  1/DATA_WIDTH/1  output stream; i_tready  in  1  sink ready.
REQ-015 SHALL have port o_done  out  1  one-cycle pulse at command completion; o_busy  out  1  high when not IDLE.

Function
REQ-016 SHALL implement FSM IDLE, READ, DRAIN; o_cmd_ready=1 only in IDLE.
REQ-017 IDLE: on cmd handshake with len>0 SHALL latch addr/len, go READ; with len=0 SHALL go to IDLE, pulse o_done next cycle, emit no beats.
REQ-018 READ: SHALL issue one read (o_ram_en=1, o_ram_addr=current) per cycle while credit available, starting at the cycle after acceptance.
REQ-019 Credit SHALL be available when inflight reads + FIFO occupancy < 4 (FIFO_DEPTH); no pop lookahead.
REQ-020 Address SHALL increment by 1 per issued read, wrapping modulo 2^ADDR_WIDTH (e.g. 0x3FF -> 0x000).
REQ-021 After last read issued SHALL go DRAIN; DRAIN -> IDLE when the tlast beat handshakes, o_done pulsing the cycle after.
REQ-022 A RD_LATENCY-deep valid shift register SHALL mark returning data; marked i_ram_data SHALL be written to the 4-entry FIFO.
REQ-023 o_tvalid SHALL reflect FIFO non-empty; o_tdata/o_tlast from FIFO head; pop on o_tvalid&i_tready.
REQ-024 o_tlast SHALL be set only on the word at offset len-1.
REQ-025 First beat SHALL be valid at cycle T+2+RD_LATENCY, T = cmd handshake cycle, with i_tready=1 throughout.
REQ-026 With i_tready held 1, throughput SHALL be one word per cycle for RD_LATENCY 1 and 2.
REQ-027 With i_tready=0, o_tvalid/o_tdata/o_tlast SHALL hold stable; no read issued without credit; FIFO SHALL never overflow.
REQ-028 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-029 New command SHALL not be accepted before o_done of the current one; o_done and o_cmd_ready MAY coincide.

Reset
REQ-030 On i_rst SHALL enter IDLE, clear FIFO, credit, valid shift register; in-flight RAM data discarded.
REQ-031 Reset values: o_cmd_ready=1, o_ram_en=0, o_ram_addr=0, o_tvalid=0, o_tlast=0, o_tdata=0, o_done=0, o_busy=0.
REQ-032 Reset mid-command SHALL abort without emitting o_done or further beats.

Structure
REQ-033 State encodings and FIFO_DEPTH=4 SHALL reside in shared package ram_stream_reader_pkg.
REQ-034 The FIFO SHALL be sub-module rsr_fifo (synchronous, registered, width DATA_WIDTH+1 for tlast).

Verification
REQ-035 Cmd addr=0x010 len=4, tready=1, RD_LATENCY=1 -> 4 beats mem[0x10..0x13] on cycles T+3..T+6, tlast on 4th, o_done at T+7.
REQ-036 Cmd addr=0x3FE len=4 -> reads 0x3FE,0x3FF,0x000,0x001 in order.
REQ-037 len=16, tready toggled 1/0 each cycle, RD_LATENCY=2 -> 16 beats in order, no loss/duplication, inflight+occupancy<=4 always.
REQ-038 Cmd len=0 -> no o_ram_en, no o_tvalid, o_done pulse exactly once.
REQ-039 i_rst asserted after 3rd beat of len=8 -> outputs at reset values next cycle, no o_done; subsequent len=2 cmd completes correctly.
REQ-040 Back-to-back cmds len=3 then len=2 -> second accepted only in IDLE; 5 beats total, tlast on beats 3 and 5.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// Shared FSM encodings, FIFO sizing and the read-credit rule for the RAM stream reader.
package ram_stream_reader_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_AW    = 2;
    localparam logic [FIFO_AW:0] FIFO_FULL = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Reads already launched plus words parked in the FIFO must leave room for one more.
    function automatic logic credit_ok(input logic [2:0] inflight, input logic [FIFO_AW:0] occupancy);
        return ({1'b0, inflight} + {1'b0, occupancy}) < 4'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/rsr_fifo.sv
// Small registered FIFO holding returned RAM words with their tlast flag.
module rsr_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [FIFO_AW:0] o_count
);

    logic [WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               do_push;
    logic               do_pop;

    assign do_pop  = i_pop && (count != '0);
    assign do_push = i_push && ((count != FIFO_FULL) || do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign o_data  = mem[rd_ptr];
    assign o_empty = (count == '0);
    assign o_count = count;

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a run of RAM words out as valid/ready beats, one command at a time.
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_READ  | issuing one RAM read per cycle while FIFO credit allows
// ST_DRAIN | all reads issued, waiting for the tlast beat to leave
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    output logic                  o_ram_en,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_data,
    output logic                  o_tvalid,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tlast,
    input  logic                  i_tready,
    output logic                  o_done,
    output logic                  o_busy
);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remain_q;
    logic                  done_q;
    logic [RD_LATENCY-1:0] vld_sr;
    logic [RD_LATENCY-1:0] last_sr;
    logic [2:0]            inflight;
    logic [FIFO_AW:0]      fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  issue;
    logic                  issue_last;
    logic                  pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + 3'(vld_sr[i]);
        end
    end

    assign issue      = (state == ST_READ) && credit_ok(inflight, fifo_count);
    assign issue_last = issue && (remain_q == LEN_WIDTH'(1));
    assign pop        = !fifo_empty && i_tready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        if (i_cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q   <= i_cmd_addr;
                            remain_q <= i_cmd_len;
                            state    <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        addr_q   <= addr_q + 1'b1;
                        remain_q <= remain_q - 1'b1;
                        if (issue_last) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && fifo_head[DATA_WIDTH]) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Marks which RAM output cycles carry our data, and which of them is the final word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr[0]  <= issue;
            last_sr[0] <= issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    rsr_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (vld_sr[RD_LATENCY-1]),
        .i_data ({last_sr[RD_LATENCY-1], i_ram_data}),
        .i_pop  (pop),
        .o_data (fifo_head),
        .o_empty(fifo_empty),
        .o_count(fifo_count)
    );

    assign o_cmd_ready = (state == ST_IDLE);
    assign o_busy      = (state != ST_IDLE);
    assign o_ram_en    = issue;
    assign o_ram_addr  = addr_q;
    assign o_tvalid    = !fifo_empty;
    assign o_tdata     = fifo_head[DATA_WIDTH-1:0];
    assign o_tlast     = fifo_head[DATA_WIDTH];
    assign o_done      = done_q;

endmodule
